ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_rx_fifo_sync_fifo.sv | 58 +++++
 rtl/ps2_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path and its byte FIFO.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;
    localparam int   PS2_DATA_BITS = 8;

    // Occupancy needs one bit more than the index so that "full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is rejected and reported on drop.
module sync_fifo
    import ps2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        clrn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic                        valid,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        valid    = (count != '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop && valid;
        // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
        do_push  = push && (!full || do_pop);
        drop     = push && !do_push;
        wr_ptr_d = do_push ? wr_ptr_q + CW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + CW'(1) : rd_ptr_q;
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered pins, frame FSM with timeout,
// sticky error flags, and a byte FIFO with a valid/pop interface.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                             clk,
    input  logic                             clrn,
    input  logic                             ps2_clk,
    input  logic                             ps2_data,
    input  logic                             pop,
    input  logic                             clr_err,
    output logic [PS2_DATA_BITS-1:0]         data,
    output logic                             valid,
    output logic [cnt_width(FIFO_DEPTH)-1:0] count,
    output logic                             overflow,
    output logic                             parity_err,
    output logic                             frame_err
);

    localparam int BW  = $clog2(PS2_DATA_BITS);
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BW-1:0]  BIT_LAST  = BW'(PS2_DATA_BITS - 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0]   dat_sync_q, dat_sync_d;
    logic                     ps2_clk_s, ps2_dat_s;
    logic                     clk_f_q, clk_f_d;
    logic [FCW-1:0]           filt_cnt_q, filt_cnt_d;
    logic                     sample_q, sample_d;

    ps2_state_e               state_q, state_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     par_q, par_d;

    logic                     overflow_q, overflow_d;
    logic                     parity_err_q, parity_err_d;
    logic                     frame_err_q, frame_err_d;

    logic                     push;
    logic                     drop;
    logic                     perr_evt;
    logic                     ferr_evt;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
        ps2_dat_s  = dat_sync_q[SYNC_STAGES-1];

        // Any sample agreeing with clk_f restarts the run, so short glitches never propagate.
        clk_f_d    = clk_f_q;
        filt_cnt_d = '0;
        if (ps2_clk_s != clk_f_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_f_d = ps2_clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end
        sample_d = clk_f_q && !clk_f_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_d     = tmo_q;
        shift_d   = shift_q;
        par_d     = par_q;
        push      = 1'b0;
        perr_evt  = 1'b0;
        ferr_evt  = 1'b0;

        if (sample_q) begin
            tmo_d = '0;
            case (state_q)
                IDLE: begin
                    if (ps2_dat_s == PS2_START_BIT) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {ps2_dat_s, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = ps2_dat_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(^{shift_q, par_q})) begin
                        perr_evt = 1'b1;
                    end else if (ps2_dat_s != PS2_STOP_BIT) begin
                        ferr_evt = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // A stalled device leaves a partial frame; drop it so the next start bit resyncs.
            if (tmo_q == TMO_LAST) begin
                state_d  = IDLE;
                tmo_d    = '0;
                ferr_evt = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        overflow_d   = (overflow_q   && !clr_err) || drop;
        parity_err_d = (parity_err_q && !clr_err) || perr_evt;
        frame_err_d  = (frame_err_q  && !clr_err) || ferr_evt;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_f_q      <= 1'b1;
            filt_cnt_q   <= '0;
            sample_q     <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            tmo_q        <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_f_q      <= clk_f_d;
            filt_cnt_q   <= filt_cnt_d;
            sample_q     <= sample_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tmo_q        <= tmo_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .wdata (shift_q),
        .rdata (data),
        .valid (valid),
        .count (count),
        .drop  (drop)
    );

    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a table of single frames, hand-written corner sequences, and
// randomised traffic checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       pop;
    logic       clr_err;
    logic [7:0] data;
    logic       valid;
    logic [3:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_ovf, m_perr, m_ferr;

    typedef struct {
        logic [7:0] b;
        logic       pflip;
        logic       stop;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl[8];

    ps2_rx_fifo #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2),
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .pop        (pop),
        .clr_err    (clr_err),
        .data       (data),
        .valid      (valid),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Odd parity: data bits plus parity bit XOR to 1.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic pflip, input logic stop);
        return {stop, (~^b) ^ pflip, b, 1'b0};
    endfunction

    // One PS/2 bit; optionally raises pop for the exact cycle the stop-bit sample pushes.
    task automatic clk_pulse(input logic b, input bit pop_here);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        if (pop_here) begin
            tick(6);
            pop = 1'b1;
            tick(1);
            pop = 1'b0;
            tick(HALF - 7);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_stop);
        for (int i = 0; i < n; i++) begin
            clk_pulse(bits[i], pop_at_stop && (i == 10));
        end
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic pflip, input logic stop);
        if (pflip) m_perr = 1'b1;
        else if (!stop) m_ferr = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic check_state(input string name);
        chk({name, " count"}, 32'(count), 32'(mq.size()));
        chk({name, " valid"}, 32'(valid), 32'(mq.size() > 0));
        chk({name, " overflow"}, 32'(overflow), 32'(m_ovf));
        chk({name, " parity_err"}, 32'(parity_err), 32'(m_perr));
        chk({name, " frame_err"}, 32'(frame_err), 32'(m_ferr));
        if (mq.size() > 0) chk({name, " head"}, 32'(data), 32'(mq[0]));
    endtask

    task automatic pop_one(input string name);
        chk({name, " valid"}, 32'(valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk({name, " data"}, 32'(data), 32'(mq[0]));
        pop = 1'b1;
        tick(1);
        pop = 1'b0;
        if (mq.size() > 0) mq.delete(0);
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        int         kind;
        int         npop;

        clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; pop = 1'b0; clr_err = 1'b0;
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        tick(3);
        check_state("reset");
        clrn = 1'b1;
        tick(5);

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h29, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            send_bits(frame(tbl[i].b, tbl[i].pflip, tbl[i].stop), 11, 1'b0);
            chk($sformatf("tbl%0d count", i), 32'(count), 32'(tbl[i].exp_push));
            chk($sformatf("tbl%0d valid", i), 32'(valid), 32'(tbl[i].exp_push));
            chk($sformatf("tbl%0d parity_err", i), 32'(parity_err), 32'(tbl[i].exp_perr));
            chk($sformatf("tbl%0d frame_err", i), 32'(frame_err), 32'(tbl[i].exp_ferr));
            chk($sformatf("tbl%0d overflow", i), 32'(overflow), 32'(0));
            if (tbl[i].exp_push) begin
                chk($sformatf("tbl%0d data", i), 32'(data), 32'(tbl[i].b));
                pop = 1'b1;
                tick(1);
                pop = 1'b0;
                chk($sformatf("tbl%0d popped valid", i), 32'(valid), 32'(0));
                chk($sformatf("tbl%0d popped count", i), 32'(count), 32'(0));
            end
            do_clr();
            chk($sformatf("tbl%0d cleared perr", i), 32'(parity_err), 32'(0));
            chk($sformatf("tbl%0d cleared ferr", i), 32'(frame_err), 32'(0));
        end

        // Short clock glitch and a lone pulse with data high must both leave the FSM idle.
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(20);
        clk_pulse(1'b1, 1'b0);
        tick(TMO + 50);
        check_state("glitch/false start");

        for (int i = 1; i <= 9; i++) begin
            send_bits(frame(8'(i), 1'b0, 1'b1), 11, 1'b0);
            model_frame(8'(i), 1'b0, 1'b1);
        end
        check_state("overflow");
        for (int i = 0; i < 8; i++) pop_one($sformatf("ovf pop%0d", i));
        check_state("ovf drained");
        do_clr();

        send_bits(frame(8'h5A, 1'b0, 1'b1), 5, 1'b0);
        tick(TMO + 50);
        m_ferr = 1'b1;
        check_state("timeout");
        do_clr();
        send_bits(frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
        model_frame(8'h5A, 1'b0, 1'b1);
        check_state("after timeout");
        pop_one("after timeout pop");

        for (int i = 0; i < 8; i++) begin
            send_bits(frame(8'h10 + 8'(i), 1'b0, 1'b1), 11, 1'b0);
            model_frame(8'h10 + 8'(i), 1'b0, 1'b1);
        end
        check_state("filled");
        send_bits(frame(8'h77, 1'b0, 1'b1), 11, 1'b1);
        mq.delete(0);
        mq.push_back(8'h77);
        check_state("full push+pop");
        for (int i = 0; i < 8; i++) pop_one($sformatf("full pop%0d", i));

        send_bits(frame(8'h33, 1'b0, 1'b1), 11, 1'b0);
        model_frame(8'h33, 1'b0, 1'b1);
        send_bits(frame(8'h44, 1'b1, 1'b1), 11, 1'b0);
        model_frame(8'h44, 1'b1, 1'b1);
        check_state("pre reset");
        send_bits(frame(8'h29, 1'b0, 1'b1), 5, 1'b0);
        clrn = 1'b0;
        #1;
        chk("midreset valid", 32'(valid), 32'(0));
        chk("midreset count", 32'(count), 32'(0));
        chk("midreset parity_err", 32'(parity_err), 32'(0));
        chk("midreset frame_err", 32'(frame_err), 32'(0));
        chk("midreset overflow", 32'(overflow), 32'(0));
        mq.delete();
        m_perr = 1'b0;
        tick(1);
        clrn = 1'b1;
        tick(5);
        send_bits(frame(8'h29, 1'b0, 1'b1), 11, 1'b0);
        model_frame(8'h29, 1'b0, 1'b1);
        check_state("after reset");
        pop_one("after reset pop");

        for (int n = 0; n < 40; n++) begin
            rb   = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            send_bits(frame(rb, kind == 0, kind != 1), 11, 1'b0);
            model_frame(rb, kind == 0, kind != 1);
            check_state($sformatf("rnd%0d", n));
            npop = int'($urandom_range(0, 2));
            for (int k = 0; k < npop; k++) pop_one($sformatf("rnd%0d pop%0d", n, k));
            if ($urandom_range(0, 3) == 0) do_clr();
            check_state($sformatf("rnd%0d post", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
